// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer controller: all-or-nothing burst writes of up to MAXW entries.
// Accept/wcount are combinational off registered free; pointers and flags update one cycle after.
module fifo_wr_ctrl #(
  parameter int ALEN         = 3,
  parameter int MAXW         = 4,
  parameter int AFULL_THRESH = 2,
  parameter int CW           = $clog2(MAXW + 1)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_wen,
  input  logic [CW-1:0]   i_wcount,
  input  logic [ALEN:0]   i_rptr,
  input  logic            i_clr_ovf,
  output logic            o_ram_wen,
  output logic [CW-1:0]   o_ram_wcount,
  output logic [ALEN-1:0] o_waddr,
  output logic [ALEN:0]   o_wptr,
  output logic [ALEN:0]   o_wptr_gray,
  output logic [ALEN:0]   o_wfree,
  output logic            o_wfull,
  output logic            o_wafull,
  output logic            o_woverflow
);

  localparam int PW = ALEN + 1;
  // One extra bit so requests above MAXW or the depth never alias when compared.
  localparam int XW = ALEN + 2;

  localparam logic [XW-1:0] MAXW_X  = XW'(MAXW);
  localparam logic [PW-1:0] DEPTH   = PW'(2 ** ALEN);
  localparam logic [PW-1:0] AFULL_P = PW'(AFULL_THRESH);

  logic [XW-1:0] wcount_x;
  logic [XW-1:0] free_x;
  logic [PW-1:0] wcount_p;
  logic          req;
  logic          fits;
  logic          accept;
  logic          reject;
  logic [PW-1:0] wptr_d;
  logic [PW-1:0] used_d;
  logic [PW-1:0] free_d;
  logic [PW-1:0] gray_d;

  always_comb begin
    wcount_x = XW'(i_wcount);
    free_x   = XW'(o_wfree);
    wcount_p = PW'(i_wcount);
    req      = i_wen & (|i_wcount);
    fits     = (wcount_x <= MAXW_X) && (wcount_x <= free_x);
    accept   = req & fits;
    reject   = req & ~fits;
    wptr_d   = accept ? (o_wptr + wcount_p) : o_wptr;
    // Occupancy uses the read pointer as seen this cycle, so free never over-reports.
    used_d   = wptr_d - i_rptr;
    free_d   = DEPTH - used_d;
    gray_d   = wptr_d ^ (wptr_d >> 1);
  end

  assign o_ram_wen    = accept;
  assign o_ram_wcount = accept ? i_wcount : '0;
  assign o_waddr      = o_wptr[ALEN-1:0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_wptr      <= '0;
      o_wptr_gray <= '0;
      o_wfree     <= DEPTH;
      o_wfull     <= 1'b0;
      o_wafull    <= 1'b0;
      o_woverflow <= 1'b0;
    end else begin
      o_wptr      <= wptr_d;
      o_wptr_gray <= gray_d;
      o_wfree     <= free_d;
      o_wfull     <= (free_d == '0);
      o_wafull    <= (free_d <= AFULL_P);
      // A reject in the same cycle as a clear keeps the flag set.
      if (reject)
        o_woverflow <= 1'b1;
      else if (i_clr_ovf)
        o_woverflow <= 1'b0;
    end
  end

endmodule

// File: doc/fifo_wr_ctrl.md
# fifo_wr_ctrl

Write-side pointer controller for the AXI-Stream FIFO with multi-entry (burst) writes. It accepts up to MAXW entries per cycle on an all-or-nothing basis and maintains the binary and Gray write pointers. It also registers the free count and the full/almost-full flags, and latches a clearable overflow flag. It sits between the upstream write interface and the dual-port RAM. It replaces the single-increment write pointer.

## Interface
Parameters:
- ALEN, 3 — address width; depth = 2^ALEN; pointers are ALEN+1 bits.
- MAXW, 4 — maximum entries per write; 1 ≤ MAXW ≤ 2^ALEN.
- AFULL_THRESH, 2 — almost-full asserts when free ≤ AFULL_THRESH; 0 ≤ AFULL_THRESH < 2^ALEN.
- CW, $clog2(MAXW+1) — count width (derived).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- i_wen  in  1  write request.
- i_wcount  in  CW  entries requested this cycle.
- i_rptr  in  ALEN+1  binary read pointer, already in the clk domain.
- i_clr_ovf  in  1  clears o_woverflow.
- o_ram_wen  out  1  write accepted this cycle.
- o_ram_wcount  out  CW  entries written; equals i_wcount when o_ram_wen is high, otherwise 0.
- o_waddr  out  ALEN  first RAM address; equals o_wptr[ALEN-1:0].
- o_wptr  out  ALEN+1  binary write pointer.
- o_wptr_gray  out  ALEN+1  Gray-coded write pointer, for the async synchroniser.
- o_wfree  out  ALEN+1  free entries, 0..2^ALEN.
- o_wfull  out  1  o_wfree == 0.
- o_wafull  out  1  o_wfree ≤ AFULL_THRESH.
- o_woverflow  out  1  sticky: a write was rejected.

## Operation
- **Accept:** accept = i_wen & (i_wcount != 0) & (i_wcount ≤ MAXW) & (i_wcount ≤ o_wfree).
  - o_ram_wen = accept. Decided purely from registered o_wfree.
- **Reject:** i_wen & (i_wcount != 0) & (i_wcount > MAXW or i_wcount > o_wfree).
  - No pointer movement; no partial writes.
  - o_woverflow sets on the next edge.
- **Zero count:** i_wen with i_wcount == 0 is a no-op. No overflow.
- **Next pointer:** wptr_d = o_wptr + i_wcount when accepted, else o_wptr. Arithmetic is modulo 2^(ALEN+1); the MSB toggles on each wrap.
- **RAM addressing:** the RAM writes entries at addresses o_waddr, o_waddr+1, … modulo 2^ALEN.
- **Free count:** free_d = 2^ALEN − ((wptr_d − i_rptr) mod 2^(ALEN+1)).
  - o_wfree, o_wfull and o_wafull register free_d.
  - i_rptr is assumed never to lead the write pointer.
- **Gray pointer:** o_wptr_gray registers wptr_d ^ (wptr_d >> 1) on the same edge as o_wptr.
- **Overflow flag:**
  - Set on reject.
  - Cleared by i_clr_ovf.
  - A reject in the same cycle as i_clr_ovf leaves o_woverflow = 1 (set wins).

## Timing
- **Reset values** (rstn low at an edge):
  - o_wptr = 0, o_wptr_gray = 0, o_waddr = 0.
  - o_wfree = 2^ALEN, o_wfull = 0, o_wafull = 0, o_woverflow = 0.
  - o_ram_wen and o_ram_wcount are combinational, so they are 0 whenever i_wen = 0.
- **Reset mid-burst:** reset overrides any accept in the same cycle. The pointer returns to 0.
- **Combinational accept:** o_ram_wen and o_ram_wcount follow the inputs with 0-cycle latency.
- **Registered outputs:** pointer, Gray pointer and flags update 1 cycle after an accept.
- **Read-side lag:** an i_rptr change appears in o_wfree 1 cycle later. The free count is therefore conservative and the block never over-accepts.
- **Simultaneous write and read-pointer change:** free_d uses both the new wptr_d and the current i_rptr.
- **Full state:** o_wfull = 1 blocks every nonzero write. Each such write sets overflow.
- **Exact fit:** a write of exactly o_wfree entries is accepted, and o_wfull asserts on the next cycle.

## Test plan
Bench parameters: ALEN=3, MAXW=4, AFULL_THRESH=2.

1. **Reset:** drive rstn=0 for 2 cycles, then release. Required: o_wptr=0, o_wfree=8, o_wfull=0, o_wafull=0, o_woverflow=0, o_ram_wen=0.
2. **Burst fill** with i_rptr=0:
   - Write 4 → o_wptr=4, o_wfree=4.
   - Write 3 → o_wptr=7, o_wfree=1, o_wafull=1.
   - Write 2 → o_ram_wen=0 and o_wptr stays 7; o_woverflow=1 next cycle.
   - Write 1 → o_wptr=8, o_waddr=0, o_wfree=0, o_wfull=1.
3. **Release and wrap:**
   - From full at o_wptr=8, set i_rptr=3 → next cycle o_wfree=3, o_wfull=0, o_wafull=0.
   - Write 3 → o_ram_wen=1 with o_waddr=0. Next cycle: o_wptr=11, o_wptr_gray=4'b1110, o_wfree=0.
4. **Overflow clear:**
   - i_clr_ovf alone → o_woverflow=0 next cycle.
   - Rejected write and i_clr_ovf in the same cycle → o_woverflow=1.
5. **Illegal and zero counts:**
   - i_wen with i_wcount=0 → no accept, no overflow, pointer unchanged.
   - i_wcount=5 (> MAXW) with o_wfree=8 → rejected, o_woverflow=1.
6. **Long run:** random 1–4 writes with i_rptr trailing, for at least 64 cycles. Required:
   - o_wptr wraps 15→0.
   - o_wptr_gray changes by exactly 1 bit per unit increment and always equals the Gray code of o_wptr.
   - o_wfree always equals the model value.
   - o_ram_wen never fires with i_wcount > o_wfree.
